// File: rtl/bram_wr_sink_pkg.sv
// Shared definitions for the BRAM write sink: FSM state encoding and
// default geometry used by the top level and the pending-address queue.
package bram_wr_sink_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 8;
    localparam int unsigned DATA_W_DEFAULT = 32;
    localparam int unsigned QDEPTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

endpackage

// File: rtl/bram_wr_sink_addr_fifo.sv
// Pending readback-address queue: circular buffer with occupancy count.
// DEPTH must be a power of two and at least 2.
module addr_fifo
    import bram_wr_sink_pkg::*;
#(
    parameter int unsigned WIDTH = ADDR_W_DEFAULT,
    parameter int unsigned DEPTH = QDEPTH_DEFAULT,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] slots [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign head  = slots[rd_ptr];

    // A pop on the same edge frees the head slot, so a push into a full queue still lands.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) slots[wr_ptr] <= din;
    end

endmodule

// File: rtl/bram_wr_sink.sv
// Strobe-driven BRAM writer that reads every written word back in write
// order and presents it on a valid/ready output port.
module bram_wr_sink
    import bram_wr_sink_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned QDEPTH = QDEPTH_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wbit,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_busy,
    output logic              o_overflow,
    output logic [15:0]       o_wr_count
);

    localparam int unsigned CNT_W = $clog2(QDEPTH) + 1;

    state_t state;
    state_t state_next;

    logic              wbit_prev;
    logic              wr_en;
    logic              pop;
    logic              load_out;
    logic              q_full;
    logic              q_empty;
    logic [CNT_W-1:0]  q_count;
    logic [ADDR_W-1:0] q_head;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] mem [2**ADDR_W];

    assign wr_en = i_wbit && !wbit_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) wbit_prev <= 1'b0;
        else          wbit_prev <= i_wbit;
    end

    addr_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .push  (wr_en),
        .pop   (pop),
        .din   (i_addr),
        .head  (q_head),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    // Simple dual-port RAM, registered read; non-blocking update gives read-first on collision.
    always_ff @(posedge i_clk) begin
        if (wr_en) mem[i_addr] <= i_data;
        if (pop)   rd_data <= mem[q_head];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        load_out   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!q_empty) begin
                    pop        = 1'b1;
                    state_next = ST_RD;
                end
            end
            ST_RD: begin
                load_out   = 1'b1;
                state_next = ST_OUT;
            end
            ST_OUT: begin
                if (i_ready) begin
                    if (!q_empty) begin
                        pop        = 1'b1;
                        state_next = ST_RD;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_addr    <= '0;
            o_addr     <= '0;
            o_data     <= '0;
            o_overflow <= 1'b0;
            o_wr_count <= '0;
        end else begin
            if (pop)      rd_addr <= q_head;
            if (load_out) begin
                o_addr <= rd_addr;
                o_data <= rd_data;
            end
            if (wr_en && q_full && !pop) o_overflow <= 1'b1;
            if (wr_en)                   o_wr_count <= o_wr_count + 16'd1;
        end
    end

    assign o_valid = (state == ST_OUT);
    assign o_busy  = (state != ST_IDLE) || (q_count != '0);

endmodule

// File: tb/tb_bram_wr_sink.sv
// Scoreboard bench for bram_wr_sink: stimulus queues expected readbacks,
// an independent monitor checks each presented word against the queue.
module tb_bram_wr_sink;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wbit;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [7:0]  out_addr;
    logic [31:0] out_data;
    logic        out_valid;
    logic        ready;
    logic        busy;
    logic        overflow;
    logic [15:0] wr_count;

    exp_t        exp_q[$];
    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned writes = 0;
    bit          rand_ready = 1'b0;
    bit          held = 1'b0;

    bram_wr_sink #(
        .ADDR_W (8),
        .DATA_W (32),
        .QDEPTH (4)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_wbit     (wbit),
        .i_addr     (addr),
        .i_data     (data),
        .o_addr     (out_addr),
        .o_data     (out_data),
        .o_valid    (out_valid),
        .i_ready    (ready),
        .o_busy     (busy),
        .o_overflow (overflow),
        .o_wr_count (wr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) ready = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_valid",    64'(out_valid), 64'd0);
        chk("rst_busy",     64'(busy),      64'd0);
        chk("rst_overflow", 64'(overflow),  64'd0);
        chk("rst_wr_count", 64'(wr_count),  64'd0);
        chk("rst_addr",     64'(out_addr),  64'd0);
        chk("rst_data",     64'(out_data),  64'd0);
        exp_q.delete();
        writes = 0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic strobe(input logic [7:0] a, input logic [31:0] d,
                          input int unsigned width, input bit expect_out);
        exp_t e;
        wbit = 1'b1;
        addr = a;
        data = d;
        if (expect_out) begin
            e.addr = a;
            e.data = d;
            exp_q.push_back(e);
        end
        writes++;
        tick();
        for (int unsigned i = 1; i < width; i++) begin
            addr = 8'($urandom);
            data = $urandom;
            tick();
        end
        wbit = 1'b0;
        addr = 8'($urandom);
        data = $urandom;
        tick();
    endtask

    task automatic drain();
        int unsigned n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d words still outstanding after %0d cycles, required 0", exp_q.size(), n);
            exp_q.delete();
        end
    endtask

    // Monitor: compares every presented word with the head of the expected queue.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = 1'b0;
            end else begin
                if (held) chk("hold_valid", 64'(out_valid), 64'd1);
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got addr %0h data %0h, required no output at %0t",
                                 out_addr, out_data, $time);
                        held = 1'b0;
                    end else begin
                        chk("out_addr", 64'(out_addr), 64'(exp_q[0].addr));
                        chk("out_data", 64'(out_data), 64'(exp_q[0].data));
                        if (ready) void'(exp_q.pop_front());
                        held = !ready;
                    end
                end else begin
                    held = 1'b0;
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t        e;
        int unsigned n;

        rst_n = 1'b1;
        wbit  = 1'b0;
        addr  = '0;
        data  = '0;
        ready = 1'b0;
        @(posedge clk);
        #1;

        // Single write with a 2-cycle strobe: one output, 3 edges after the strobe is driven.
        do_reset();
        ready = 1'b1;
        wbit  = 1'b1;
        addr  = 8'h01;
        data  = 32'hDEADBEEF;
        e.addr = 8'h01;
        e.data = 32'hDEADBEEF;
        exp_q.push_back(e);
        writes++;
        tick();
        chk("lat_edge1_valid", 64'(out_valid), 64'd0);
        tick();
        chk("lat_edge2_valid", 64'(out_valid), 64'd0);
        wbit = 1'b0;
        tick();
        chk("lat_edge3_valid", 64'(out_valid), 64'd1);
        drain();
        tick();
        tick();
        chk("single_wr_count", 64'(wr_count), 64'(16'(writes)));
        chk("single_busy", 64'(busy), 64'd0);

        // Generator pattern: period 15, strobe at counts 10-11, addresses 1..20, data addr*3.
        do_reset();
        ready = 1'b1;
        for (int unsigned k = 1; k <= 20; k++) begin
            for (int unsigned c = 0; c < 15; c++) begin
                wbit = (c == 10 || c == 11);
                addr = 8'(k);
                data = 32'(k * 3);
                if (c == 10) begin
                    e.addr = 8'(k);
                    e.data = 32'(k * 3);
                    exp_q.push_back(e);
                    writes++;
                end
                tick();
            end
        end
        wbit = 1'b0;
        drain();
        chk("gen_wr_count", 64'(wr_count), 64'(16'(writes)));
        chk("gen_overflow", 64'(overflow), 64'd0);

        // Backpressure: first word held on the output, four queued, sixth dropped.
        do_reset();
        ready = 1'b0;
        for (int unsigned k = 0; k < 6; k++)
            strobe(8'(8'h10 + k), $urandom, 1, (k < 5));
        tick();
        chk("bp_valid", 64'(out_valid), 64'd1);
        chk("bp_addr", 64'(out_addr), 64'h10);
        chk("bp_overflow", 64'(overflow), 64'd1);
        ready = 1'b1;
        drain();
        tick();
        tick();
        chk("bp_busy", 64'(busy), 64'd0);
        chk("bp_overflow_sticky", 64'(overflow), 64'd1);
        chk("bp_wr_count", 64'(wr_count), 64'(16'(writes)));

        // Reset while presenting with two addresses queued.
        do_reset();
        ready = 1'b0;
        strobe(8'h40, $urandom, 1, 1'b1);
        strobe(8'h41, $urandom, 1, 1'b1);
        strobe(8'h42, $urandom, 1, 1'b1);
        chk("mid_valid_before", 64'(out_valid), 64'd1);
        do_reset();
        ready = 1'b1;
        repeat (10) tick();
        chk("mid_busy_after", 64'(busy), 64'd0);
        strobe(8'h07, 32'h0000_0777, 1, 1'b1);
        drain();
        chk("mid_wr_count", 64'(wr_count), 64'(16'(writes)));

        // Strobe already high at reset release counts as a rising edge.
        wbit = 1'b1;
        addr = 8'h22;
        data = 32'h1234_5678;
        do_reset();
        e.addr = 8'h22;
        e.data = 32'h1234_5678;
        exp_q.push_back(e);
        writes++;
        tick();
        wbit = 1'b0;
        drain();
        chk("rel_wr_count", 64'(wr_count), 64'(16'(writes)));

        // Same-address collision: rewrite lands on the edge that reads the old word.
        do_reset();
        ready = 1'b0;
        strobe(8'h30, $urandom, 1, 1'b1);
        strobe(8'h05, 32'h0000_AAAA, 1, 1'b1);
        tick();
        chk("col_presenting", 64'(out_valid), 64'd1);
        ready = 1'b1;
        wbit  = 1'b1;
        addr  = 8'h05;
        data  = 32'h0000_BBBB;
        e.addr = 8'h05;
        e.data = 32'h0000_BBBB;
        exp_q.push_back(e);
        writes++;
        tick();
        wbit = 1'b0;
        drain();

        // Randomised traffic with random backpressure, never more than 4 outstanding.
        do_reset();
        rand_ready = 1'b1;
        for (int unsigned i = 0; i < 300; i++) begin
            n = 0;
            while (exp_q.size() > 3 && n < 200) begin
                tick();
                n++;
            end
            if (exp_q.size() > 3) begin
                checks++;
                errors++;
                $display("FAIL rand_stall: %0d outstanding after %0d cycles, required at most 3", exp_q.size(), n);
                exp_q.delete();
            end
            repeat ($urandom_range(0, 3)) tick();
            strobe(8'(32'h80 + i), $urandom, $urandom_range(1, 3), 1'b1);
        end
        rand_ready = 1'b0;
        ready = 1'b1;
        drain();
        chk("rand_overflow", 64'(overflow), 64'd0);
        chk("rand_wr_count", 64'(wr_count), 64'(16'(writes)));

        // Write counter wrap after 65535 + 1 writes.
        do_reset();
        ready = 1'b1;
        for (int unsigned i = 0; i < 65535; i++)
            strobe(8'(i), $urandom, 1, 1'b1);
        chk("wrap_pre", 64'(wr_count), 64'(16'(writes)));
        strobe(8'hEE, $urandom, 1, 1'b1);
        chk("wrap_post", 64'(wr_count), 64'(16'(writes)));
        drain();
        chk("wrap_overflow", 64'(overflow), 64'd0);

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
